// File: rtl/mux16.sv
// Runtime-indexed single-bit selector with a combinational output and an
// enable-captured registered copy that remembers whether it was ever loaded.
module mux16 #(
    parameter int N_IN  = 16,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  in,
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic             out,
    output logic             out_q,
    output logic             out_q_valid
);

    // Compare-and-pick loop never indexes past N_IN, so an out-of-range
    // select on a non-power-of-two width falls through to the 0 default.
    always_comb begin
        out = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                out = in[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= 1'b0;
            out_q_valid <= 1'b0;
        end else if (en) begin
            out_q       <= out;
            out_q_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux16.sv
// Bench for mux16: table-driven combinational vectors plus a scoreboard for
// the registered path, on a 16-input and a 10-input instance.
module tb_mux16;

    logic        clk;
    logic        rst;
    logic [15:0] in16;
    logic [3:0]  sel16;
    logic        en16;
    logic        out16, out_q16, out_q_valid16;
    logic [9:0]  in10;
    logic [3:0]  sel10;
    logic        en10;
    logic        out10, out_q10, out_q_valid10;

    int total = 0;
    int bad   = 0;

    logic [1:0] exp_q[$];
    logic       model_q16, model_v16, model_q10, model_v10;

    typedef struct {
        logic [15:0] in;
        logic [3:0]  sel;
        logic        exp;
    } comb_vec_t;

    comb_vec_t tbl[6];

    mux16 #(.N_IN(16), .SEL_W(4)) dut16 (
        .clk(clk), .rst(rst), .in(in16), .sel(sel16), .en(en16),
        .out(out16), .out_q(out_q16), .out_q_valid(out_q_valid16)
    );

    mux16 #(.N_IN(10), .SEL_W(4)) dut10 (
        .clk(clk), .rst(rst), .in(in10), .sel(sel10), .en(en10),
        .out(out10), .out_q(out_q10), .out_q_valid(out_q_valid10)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d", total);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ref_sel16(input logic [15:0] v, input logic [3:0] s);
        return v[s];
    endfunction

    function automatic logic ref_sel10(input logic [9:0] v, input logic [3:0] s);
        if (s < 4'd10) return v[s];
        return 1'b0;
    endfunction

    // Drive one clock worth of stimulus, push the expected registered state,
    // then pop and compare after the edge.
    task automatic cycle16(input logic r, input logic e, input logic [15:0] v,
                           input logic [3:0] s, input string name);
        logic [1:0] exp;
        rst = r; en16 = e; in16 = v; sel16 = s;
        if (r) begin
            model_q16 = 1'b0; model_v16 = 1'b0;
        end else if (e) begin
            model_q16 = ref_sel16(v, s); model_v16 = 1'b1;
        end
        exp_q.push_back({model_v16, model_q16});
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        check({name, "_q16"}, {30'd0, out_q_valid16, out_q16}, {30'd0, exp});
    endtask

    task automatic cycle10(input logic e, input logic [9:0] v,
                           input logic [3:0] s, input string name);
        logic [1:0] exp;
        rst = 1'b0; en10 = e; in10 = v; sel10 = s;
        if (e) begin
            model_q10 = ref_sel10(v, s); model_v10 = 1'b1;
        end
        exp_q.push_back({model_v10, model_q10});
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        check({name, "_q10"}, {30'd0, out_q_valid10, out_q10}, {30'd0, exp});
    endtask

    initial begin
        logic [15:0] v;
        logic [3:0]  s;
        logic        e;

        tbl[0] = '{16'h3f0a, 4'd0,  1'b0};
        tbl[1] = '{16'h3f0a, 4'd1,  1'b1};
        tbl[2] = '{16'h3f0a, 4'd6,  1'b0};
        tbl[3] = '{16'h3f0a, 4'd12, 1'b1};
        tbl[4] = '{16'h8000, 4'd15, 1'b1};
        tbl[5] = '{16'h7fff, 4'd15, 1'b0};

        rst = 1'b1; en16 = 1'b0; en10 = 1'b0;
        in16 = 16'h0; sel16 = 4'd0; in10 = 10'h0; sel10 = 4'd0;
        model_q16 = 1'b0; model_v16 = 1'b0; model_q10 = 1'b0; model_v10 = 1'b0;

        // reset state, with out still following its inputs during reset
        repeat (2) @(posedge clk);
        #1;
        in16 = 16'h0004; sel16 = 4'd2;
        #1;
        check("rst_out_q16", {31'd0, out_q16}, 32'd0);
        check("rst_valid16", {31'd0, out_q_valid16}, 32'd0);
        check("rst_out_q10", {31'd0, out_q10}, 32'd0);
        check("rst_valid10", {31'd0, out_q_valid10}, 32'd0);
        check("rst_out_comb", {31'd0, out16}, 32'd1);
        rst = 1'b0;

        // combinational table
        for (int i = 0; i < 6; i++) begin
            in16 = tbl[i].in; sel16 = tbl[i].sel;
            #5;
            check($sformatf("tbl%0d", i), {31'd0, out16}, {31'd0, tbl[i].exp});
        end

        // one-hot sweep
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                v = 16'h0001 << i;
                in16 = v; sel16 = 4'(j);
                #1;
                check($sformatf("onehot_i%0d_s%0d", i, j), {31'd0, out16},
                      {31'd0, (i == j)});
            end
        end

        // random combinational
        for (int k = 0; k < 20; k++) begin
            v = 16'($urandom_range(0, 65535));
            s = 4'($urandom_range(0, 15));
            in16 = v; sel16 = s;
            #1;
            check($sformatf("rnd_comb%0d", k), {31'd0, out16}, {31'd0, ref_sel16(v, s)});
        end

        // registered capture then hold with en low
        cycle16(1'b0, 1'b1, 16'h3f0a, 4'd1, "cap");
        for (int k = 0; k < 3; k++) begin
            cycle16(1'b0, 1'b0, 16'h3f0a, 4'd6, $sformatf("hold%0d", k));
            check($sformatf("hold_out%0d", k), {31'd0, out16}, 32'd0);
        end

        // reset wins over enable, then recapture
        cycle16(1'b1, 1'b1, 16'h3f0a, 4'd1, "rst_pri");
        cycle16(1'b0, 1'b1, 16'h3f0a, 4'd12, "recap");

        // random registered traffic, with occasional mid-run reset
        for (int k = 0; k < 40; k++) begin
            v = 16'($urandom_range(0, 65535));
            s = 4'($urandom_range(0, 15));
            e = 1'($urandom_range(0, 1));
            cycle16(($urandom_range(0, 15) == 0), e, v, s, $sformatf("rnd_reg%0d", k));
        end
        rst = 1'b0;

        // non-power-of-two instance: out-of-range selects read as 0
        in10 = 10'h3ff; sel10 = 4'd12;
        #5;
        check("oor_out10", {31'd0, out10}, 32'd0);
        cycle10(1'b1, 10'h3ff, 4'd12, "oor_cap");
        cycle10(1'b1, 10'h3ff, 4'd9, "inr_cap");
        for (int j = 10; j < 16; j++) begin
            in10 = 10'h3ff; sel10 = 4'(j);
            #1;
            check($sformatf("oor_sweep%0d", j), {31'd0, out10}, 32'd0);
        end
        for (int j = 0; j < 10; j++) begin
            in10 = 10'h3ff; sel10 = 4'(j);
            #1;
            check($sformatf("inr_sweep%0d", j), {31'd0, out10}, 32'd1);
        end

        check("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
